// File: rtl/calc_multiport.sv
// -----------------------------------------------------------------------------
// calc_multiport
//
// Multi-port calculator core. Each of NPORTS request ports takes a two-cycle
// request: command plus operand 1 in the first cycle, operand 2 in the second.
// The request is queued in a DEPTH-entry FIFO for that port. A round-robin
// arbiter picks one queued request per cycle for a shared single-cycle ALU.
// The result is registered onto the response port of the originating port and
// held there for exactly one cycle.
//
// Parameters
//   NPORTS : number of request/response ports (1..8)
//   DW     : operand/result width (>= 8, power of two)
//   DEPTH  : per-port request FIFO depth (>= 1)
//
// Ports
//   c_clk       : clock; all logic runs on the rising edge
//   reset       : synchronous, active-high reset
//   req_cmd_in  : [NPORTS*4]  per-port command, port p at [4p+3:4p]
//   req_data_in : [NPORTS*DW] per-port operand, port p at [DW*p +: DW]
//   out_resp    : [NPORTS*2]  per-port response code, port p at [2p+1:2p]
//   out_data    : [NPORTS*DW] per-port result, port p at [DW*p +: DW]
//
// Commands : 0 no-op, 1 add, 2 sub, 5 shl, 6 shr (logical), 3 mul (optional)
// Responses: 00 none, 01 ok, 10 overflow/underflow/invalid, 11 dropped (full)
//
// Build option
//   CALC_MULT_EN : when defined, command 4'h3 is a truncating multiply that
//                  flags any non-zero upper product bit. When undefined, no
//                  multiplier is built and 4'h3 is an invalid command.
// -----------------------------------------------------------------------------
module calc_multiport #(
  parameter int NPORTS = 4,
  parameter int DW     = 32,
  parameter int DEPTH  = 2
) (
  input  logic                 c_clk,
  input  logic                 reset,
  input  logic [NPORTS*4-1:0]  req_cmd_in,
  input  logic [NPORTS*DW-1:0] req_data_in,
  output logic [NPORTS*2-1:0]  out_resp,
  output logic [NPORTS*DW-1:0] out_data
);

  // Derived widths. Pointer and index widths are kept at least one bit so that
  // the degenerate DEPTH=1 / NPORTS=1 builds still elaborate.
  localparam int SW = $clog2(DW);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  // Capture FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OP2  = 1'b1;

  // Commands
  localparam logic [3:0] CMD_NOP = 4'h0;
  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
`ifdef CALC_MULT_EN
  localparam logic [3:0] CMD_MUL = 4'h3;
`endif
  localparam logic [3:0] CMD_SHL = 4'h5;
  localparam logic [3:0] CMD_SHR = 4'h6;

  // Response codes
  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;
  localparam logic [1:0] RESP_DROP = 2'b11;

  typedef struct packed {
    logic [3:0]    cmd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
  } entry_t;

  // Port index arithmetic modulo NPORTS.
  function automatic logic [IW-1:0] port_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NPORTS) s = s - NPORTS;
    return IW'(s);
  endfunction

  // FIFO pointer increment modulo DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Per-port state exported to the shared arbiter / ALU
  // ---------------------------------------------------------------------------
  logic [NPORTS-1:0]         not_empty;  // FIFO holds at least one request
  logic [NPORTS-1:0]         dropped;    // a request was dropped last cycle
  entry_t [NPORTS-1:0]       head_vec;   // oldest entry of each FIFO

  logic                      grant_vld;
  logic [IW-1:0]             grant_idx;
  logic [IW-1:0]             rr_ptr_q;

  // ---------------------------------------------------------------------------
  // Per-port capture FSM and request FIFO
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [3:0]    cmd_in;
    logic [DW-1:0] data_in;
    logic [0:0]    state_q;
    logic [3:0]    cmd_q;
    logic [DW-1:0] op1_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          drop_q;
    logic          full;
    logic          push;
    logic          pop;
    entry_t        mem_q [DEPTH];

    assign cmd_in  = req_cmd_in[4*p +: 4];
    assign data_in = req_data_in[DW*p +: DW];

    // Fullness is judged on the count at the start of the operand-2 cycle, so
    // a pop in that same cycle does not rescue the request.
    assign full = (count_q == CW'(DEPTH));
    assign push = (state_q == ST_OP2) && !full;
    assign pop  = grant_vld && (grant_idx == IW'(p));

    assign not_empty[p] = (count_q != '0);
    assign dropped[p]   = drop_q;
    assign head_vec[p]  = mem_q[rd_ptr_q];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the clock edge, regardless of
    // the order of statements or blocks.
    always_ff @(posedge c_clk) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        cmd_q    <= CMD_NOP;
        op1_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        drop_q   <= 1'b0;
      end else begin
        drop_q <= (state_q == ST_OP2) && full;

        case (state_q)
          ST_IDLE: begin
            if (cmd_in != CMD_NOP) begin
              cmd_q   <= cmd_in;
              op1_q   <= data_in;
              state_q <= ST_OP2;
            end
          end
          // The cmd input is ignored here; operand 2 goes straight into the
          // FIFO (or is dropped) at the end of this cycle.
          ST_OP2:  state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase

        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end

    // NOTE: the FIFO storage has no reset; the cleared count and pointers make
    // stale entries unreachable, and leaving it unreset lets it map to RAM.
    always_ff @(posedge c_clk) begin
      if (push) mem_q[wr_ptr_q] <= '{cmd: cmd_q, op1: op1_q, op2: data_in};
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  // A port that dropped a request last cycle owns its response slot for the
  // 2'b11 code, so it is kept out of arbitration for that one cycle.
  logic [NPORTS-1:0] req_vec;
  assign req_vec = not_empty & ~dropped;

  // NOTE: every signal written in an always_comb block gets a default at the
  // top, so no path through the block leaves it unassigned and no latch forms.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (!grant_vld && req_vec[port_add(rr_ptr_q, i)]) begin
        grant_vld = 1'b1;
        grant_idx = port_add(rr_ptr_q, i);
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (grant_vld) begin
      rr_ptr_q <= port_add(grant_idx, 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shared single-cycle ALU
  // ---------------------------------------------------------------------------
  entry_t        sel;
  logic [DW:0]   sum;
  logic [1:0]    alu_resp;
  logic [DW-1:0] alu_data;

  assign sel = head_vec[grant_idx];
  assign sum = {1'b0, sel.op1} + {1'b0, sel.op2};

`ifdef CALC_MULT_EN
  logic [2*DW-1:0] prod;
  assign prod = {{DW{1'b0}}, sel.op1} * {{DW{1'b0}}, sel.op2};
`endif

  always_comb begin
    alu_resp = RESP_ERR;
    alu_data = '0;
    case (sel.cmd)
      CMD_ADD: begin
        if (!sum[DW]) begin
          alu_resp = RESP_OK;
          alu_data = sum[DW-1:0];
        end
      end
      CMD_SUB: begin
        if (sel.op2 <= sel.op1) begin
          alu_resp = RESP_OK;
          alu_data = sel.op1 - sel.op2;
        end
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = sel.op1 << sel.op2[SW-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = sel.op1 >> sel.op2[SW-1:0];
      end
`ifdef CALC_MULT_EN
      CMD_MUL: begin
        if (prod[2*DW-1:DW] == '0) begin
          alu_resp = RESP_OK;
          alu_data = prod[DW-1:0];
        end
      end
`endif
      // Anything else that reached the FIFO is invalid: error code, data 0.
      default: begin
        alu_resp = RESP_ERR;
        alu_data = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response registers: each port shows a response for exactly one cycle and
  // returns to 00 / 0 otherwise. Drop and grant never target the same port in
  // the same cycle because of the suppression above.
  // ---------------------------------------------------------------------------
  logic [NPORTS*2-1:0]  resp_d;
  logic [NPORTS*DW-1:0] data_d;

  always_comb begin
    resp_d = '0;
    data_d = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (dropped[p]) begin
        resp_d[2*p +: 2] = RESP_DROP;
      end else if (grant_vld && (grant_idx == IW'(p))) begin
        resp_d[2*p +: 2]  = alu_resp;
        data_d[DW*p +: DW] = alu_data;
      end else begin
        resp_d[2*p +: 2] = RESP_NONE;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      out_resp <= '0;
      out_data <= '0;
    end else begin
      out_resp <= resp_d;
      out_data <= data_d;
    end
  end

endmodule

// File: doc/calc_multiport.md
# calc_multiport

Parametrised multi-port calculator core, successor to the four-port fixed-width calculator. It accepts two-cycle requests (command plus operand 1, then operand 2) on `NPORTS` independent request ports and buffers each port's requests in a `DEPTH`-entry FIFO. A round-robin arbiter feeds one shared single-cycle ALU, and the ALU returns a one-cycle response on the originating port. The block sits directly behind the request interface, in place of the fixed calculator top.

## Interface
- `NPORTS`, 4: number of request/response ports (1–8)
- `DW`, 32: operand/result width (≥8, power of two)
- `DEPTH`, 2: per-port request FIFO depth (≥1)
- `c_clk` input, 1: sole clock, all logic on rising edge
- `reset` input, 1: synchronous, active-high reset
- `req_cmd_in` input, `NPORTS*4`: per-port command, port p at `[4p+3:4p]`
- `req_data_in` input, `NPORTS*DW`: per-port operand, port p at `[DW*p+DW-1:DW*p]`
- `out_resp` output, `NPORTS*2`: per-port response code, port p at `[2p+1:2p]`
- `out_data` output, `NPORTS*DW`: per-port result

## Operation
- Commands:
  - `4'h0` no-op
  - `4'h1` add, op1+op2
  - `4'h2` subtract, op1−op2
  - `4'h5` shift left op1 by `op2[$clog2(DW)-1:0]`
  - `4'h6` shift right (logical) op1 by the same amount
  - the unused upper bits of op2 are ignored for shifts
- Response codes:
  - `2'b00` no response
  - `2'b01` success
  - `2'b10` overflow, underflow or invalid command (data 0)
  - `2'b11` request dropped, FIFO full (data 0)
- Per-port capture FSM:
  - IDLE: a non-zero cmd latches cmd/op1 and moves to OP2.
  - OP2: latches op2; the cmd input is ignored in this cycle. The FSM then pushes {cmd, op1, op2} into the FIFO, or drops it if the FIFO is full, and returns to IDLE.
- Add: a carry out of bit DW−1 gives `2'b10`, data 0.
- Subtract: op2 > op1 gives `2'b10`, data 0.
- Shifts never flag an error. Bits shifted out are lost.
- Any other non-zero command, including `4'h3` when the macro is off, is enqueued and answered with `2'b10`.
- Arbiter: each cycle it grants the first non-empty, non-suppressed port at or after the RR pointer. After a grant the pointer moves to granted+1, wrapping at `NPORTS`. Per-port order is FIFO order.
- One ALU operation per cycle. Results are registered into the granted port's `out_resp`/`out_data` only.

## Timing
- Request cycles: cmd+op1 in cycle t, op2 in cycle t+1. Enqueue happens at the edge ending t+1.
- Uncontended latency: grant in t+2, response valid in cycle t+3 for exactly one cycle. Otherwise `out_resp`=00 and `out_data`=0.
- Back-to-back requests on one port are legal: the next cmd may arrive in t+2.
- Full FIFO:
  - Fullness is sampled from the count at the start of t+1.
  - If the FIFO is full, the request is dropped and `2'b11` is emitted in t+3.
  - That port's grant is suppressed in t+2, so the two responses cannot collide.
- Simultaneous push and pop on one port in the same cycle is legal. The count is unchanged.
- With all ports saturated, each port gets one grant every `NPORTS` cycles.
- Reset values: `out_resp` and `out_data` are 0 in the cycle after `reset` is sampled high.
- Reset mid-operation clears all of the following, and no responses are produced for discarded requests:
  - FIFOs
  - capture FSMs (to IDLE)
  - the RR pointer (to 0)
  - output registers
- Requests presented while `reset` is high are ignored.

## Configuration
- `CALC_MULT_EN` defined:
  - Command `4'h3` is multiply, op1*op2 truncated to DW bits.
  - Any non-zero bit in the upper DW product bits gives `2'b10`, data 0.
  - Same single-cycle latency as the other commands.
- Not defined: no multiplier is built, and `4'h3` is an invalid command answered with `2'b10`.

## Test plan
- Reset: hold `reset` 3 cycles with random inputs. All `out_resp`/`out_data` must be 0, and no response may appear afterwards for requests made during reset.
- Basic ops on port 0, DW=32:
  - add 5,7 → `01`/12
  - add FFFF_FFFF,1 → `10`/0
  - sub 3,9 → `10`/0
  - shl 1,4 → `01`/16
  - shr 8000_0000,31 → `01`/1
  - each response must arrive exactly 3 cycles after its cmd
- Contention: all 4 ports issue add 1,p in the same cycle. Responses must arrive on ports 0,1,2,3 in consecutive cycles t+3…t+6, each `01` with data 1+p.
- Overflow of FIFO: with DEPTH=2 and the other 3 ports saturating the ALU, issue 3 back-to-back requests on port 3. The third must receive `11`/0, and the first two must complete with the correct results in order.
- Invalid and no-op: cmd `4'h7` gives `10`/0. A no-op gives no response. Cmd `4'h3` with 6,7 gives `01`/42 with `CALC_MULT_EN` and `10`/0 without it.
- Mid-operation reset: enqueue 2 requests per port, then assert `reset` for 1 cycle. There must be no responses afterwards, and a fresh add 2,2 on port 1 must return `01`/4 at the standard latency.
